window_ctrl_l1: RTL

Sequencing controller for the layer-1 sliding-window datapath. It accepts the channel-interleaved 16-bit pixel word stream for one frame and drives `shift_en` to the row delay-line buffers. It tracks channel, column and row position, and flags each cycle in which the 3×3×CH window held by the buffers is complete and non-wrapping. The block sits between the input stream source and the layer-1 convolution engine, and applies the engine's backpressure to both the stream and the delay lines.

---
 rtl/window_ctrl_l1.sv | 122 ++++++++++++
 1 files changed

// File: rtl/window_ctrl_l1.sv
// window_ctrl_l1: sequencing controller for the layer-1 sliding-window datapath.
// Accepts one frame of channel-interleaved pixel words, drives shift_en to the
// row delay lines and tags each cycle where the KxKxCH window is complete and
// does not straddle a row boundary.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a frame (only honoured in IDLE)
//   in_valid        stream word present
//   in_ready        word accepted this cycle when in_valid is also high
//   out_ready       conv engine backpressure; low freezes stream and counters
//   shift_en        advance delay lines / window registers by one word
//   out_valid       window ready at (out_row, out_col, out_ch)
//   out_row/col/ch  window top row, left column, channel
//   busy            frame in progress (RUN or DONE)
//   frame_done      one-cycle pulse after the last word is accepted
module window_ctrl_l1 #(
  parameter int IMG_W = 200,
  parameter int IMG_H = 200,
  parameter int K     = 3,
  parameter int CH    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     shift_en,
  output logic                     out_valid,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(CH)-1:0]    out_ch,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int HW = $clog2(CH);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [HW-1:0] CH_LAST  = HW'(CH - 1);
  localparam logic [RW-1:0] ROW_OFS  = RW'(K - 1);
  localparam logic [CW-1:0] COL_OFS  = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [HW-1:0] ch_cnt;
  logic          accept;
  logic          last_word;
  logic          qualify;

  assign in_ready   = (state == RUN) & out_ready;
  assign accept     = in_valid & in_ready;
  assign shift_en   = accept;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign last_word = (row_cnt == ROW_LAST) & (col_cnt == COL_LAST) & (ch_cnt == CH_LAST);
  // Columns 0..K-2 hold a window that wraps across the previous row's tail.
  assign qualify   = (row_cnt >= ROW_OFS) & (col_cnt >= COL_OFS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Position of the word currently presented on the stream.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      row_cnt <= '0;
      col_cnt <= '0;
      ch_cnt  <= '0;
    end else if (accept) begin
      if (ch_cnt == CH_LAST) begin
        ch_cnt <= '0;
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end else begin
        ch_cnt <= ch_cnt + HW'(1);
      end
    end
  end

  // A qualifying accept implies out_ready=1, so a held window is never
  // overwritten while the engine stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_ch    <= '0;
    end else if (accept && qualify) begin
      out_valid <= 1'b1;
      out_row   <= row_cnt - ROW_OFS;
      out_col   <= col_cnt - COL_OFS;
      out_ch    <= ch_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
